// File: rtl/exec_pkg.sv
// exec_pkg: shared constants, opcode/state types and single-cycle ALU for exec_unit
package exec_pkg;
    localparam int WIDTH = 16;
    localparam int REGBITS = 3;
    localparam int MUL_STEPS = 16;
    typedef enum logic [2:0] {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR, OP_MUL} op_t;
    typedef enum logic [1:0] {IDLE, MUL, WB} state_t;
    // Returns {carry, result}; bit WIDTH of a widened subtract is the unsigned borrow
    function automatic logic [WIDTH:0] alu(op_t op, logic [WIDTH-1:0] a, logic [WIDTH-1:0] b);
        case (op)
            OP_ADD: return {1'b0, a} + {1'b0, b};
            OP_SUB: return {1'b0, a} - {1'b0, b};
            OP_AND: return {1'b0, a & b};
            OP_OR:  return {1'b0, a | b};
            OP_XOR: return {1'b0, a ^ b};
            OP_SHL: return {1'b0, a << b[3:0]};
            OP_SHR: return {1'b0, a >> b[3:0]};
            default: return '0;
        endcase
    endfunction
endpackage

// File: rtl/mul_seq.sv
// mul_seq: 16-step LSB-first shift-add multiplier; product includes the step being taken this cycle
module mul_seq import exec_pkg::*; (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   product,
    output logic                 last
);
    localparam int CW = $clog2(MUL_STEPS);
    logic [2*WIDTH-1:0] acc, mcand;
    logic [WIDTH-1:0] mplier;
    logic [CW-1:0] cnt;
    logic run;
    assign product = acc + (mplier[0] ? mcand : '0);
    assign last = run && cnt == CW'(MUL_STEPS - 1);
    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
            mcand <= '0;
            mplier <= '0;
            cnt <= '0;
            run <= 1'b0;
        end else if (load) begin
            acc <= '0;
            mcand <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            cnt <= '0;
            run <= 1'b1;
        end else if (run) begin
            acc <= product;
            mcand <= mcand << 1;
            mplier <= mplier >> 1;
            cnt <= cnt + 1'b1;
            run <= !last;
        end
    end
endmodule

// File: rtl/exec_unit.sv
// exec_unit: execute stage producing one register-file write per accepted ALU or multiply op
module exec_unit import exec_pkg::*; (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [2:0]         op,
    input  logic [REGBITS-1:0] dest,
    input  logic [WIDTH-1:0]   a_in,
    input  logic [WIDTH-1:0]   b_in,
    output logic               busy,
    output logic               we,
    output logic [REGBITS-1:0] c_index,
    output logic [WIDTH-1:0]   result,
    output logic               zero,
    output logic               carry
);
    state_t state, next;
    logic [REGBITS-1:0] dest_r;
    logic [2*WIDTH-1:0] product;
    logic last;
    logic is_mul;
    logic [WIDTH:0] wb_val;
    assign is_mul = op_t'(op) == OP_MUL;
    // MUL overflow folds the whole upper half into the carry flag
    assign wb_val = state == MUL ? {|product[2*WIDTH-1:WIDTH], product[WIDTH-1:0]}
                                 : alu(op_t'(op), a_in, b_in);
    mul_seq u_mul (
        .clk(clk),
        .reset(reset),
        .load(state == IDLE && start && is_mul),
        .a(a_in),
        .b(b_in),
        .product(product),
        .last(last)
    );
    always_comb begin
        next = IDLE;
        next = state == IDLE ? (start ? (is_mul ? MUL : WB) : IDLE)
             : state == MUL  ? (last ? WB : MUL)
             : IDLE;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            busy <= 1'b0;
            we <= 1'b0;
            dest_r <= '0;
            c_index <= '0;
            result <= '0;
            zero <= 1'b0;
            carry <= 1'b0;
        end else begin
            state <= next;
            busy <= next != IDLE;
            we <= next == WB;
            if (state == IDLE && start) dest_r <= dest;
            if (next == WB) begin
                c_index <= state == IDLE ? dest : dest_r;
                result <= wb_val[WIDTH-1:0];
                zero <= wb_val[WIDTH-1:0] == '0;
                carry <= wb_val[WIDTH];
            end
        end
    end
endmodule

// File: tb/tb_exec_unit.sv
// tb_exec_unit: randomized self-checking bench for exec_unit against an arithmetic reference model
module tb_exec_unit;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic [2:0] op = '0;
    logic [2:0] dest = '0;
    logic [15:0] a_in = '0;
    logic [15:0] b_in = '0;
    logic busy, we, zero, carry;
    logic [2:0] c_index;
    logic [15:0] result;
    int total = 0;
    int bad = 0;
    int cur_op = 0;

    always #5 clk = ~clk;

    exec_unit dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .op(op),
        .dest(dest),
        .a_in(a_in),
        .b_in(b_in),
        .busy(busy),
        .we(we),
        .c_index(c_index),
        .result(result),
        .zero(zero),
        .carry(carry)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s (op=%0d) got=%0h exp=%0h", tag, cur_op, got, exp);
        end
    endtask

    // {carry, result} straight from the arithmetic definition of each opcode
    function automatic logic [16:0] model(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b);
        longint unsigned p;
        case (o)
            3'd0: begin p = longint'(a) + longint'(b); return {p > 65535, p[15:0]}; end
            3'd1: return {a < b, 16'(a - b)};
            3'd2: return {1'b0, a & b};
            3'd3: return {1'b0, a | b};
            3'd4: return {1'b0, a ^ b};
            3'd5: return {1'b0, 16'(a << b[3:0])};
            3'd6: return {1'b0, 16'(a >> b[3:0])};
            default: begin p = longint'(a) * longint'(b); return {p[31:16] != 0, p[15:0]}; end
        endcase
    endfunction

    task automatic check_zero_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_we"}, we, 0);
        check({tag, "_idx"}, c_index, 0);
        check({tag, "_res"}, result, 0);
        check({tag, "_zero"}, zero, 0);
        check({tag, "_carry"}, carry, 0);
    endtask

    task automatic run_op(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                          input logic [2:0] d, input bit pulse);
        logic [16:0] m;
        int exp_lat, lat, bcnt;
        m = model(o, a, b);
        exp_lat = (o == 3'd7) ? 17 : 1;
        lat = 0;
        bcnt = 0;
        cur_op = o;
        @(negedge clk);
        start = 1'b1; op = o; a_in = a; b_in = b; dest = d;
        for (int cyc = 1; cyc <= 40 && lat == 0; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                op = 3'($urandom); a_in = 16'($urandom); b_in = 16'($urandom); dest = 3'($urandom);
            end
            start = pulse && (cyc == 5 || we);
            bcnt += int'(busy);
            if (we) lat = cyc;
        end
        check("lat", lat, exp_lat);
        check("busy_cycles", bcnt, exp_lat);
        check("idx", c_index, d);
        check("res", result, m[15:0]);
        check("zero", zero, m[15:0] == 0);
        check("carry", carry, m[16]);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            start = 1'b0;
            check("after_we", we, 0);
            check("after_busy", busy, 0);
            check("hold_res", result, m[15:0]);
            check("hold_zero", zero, m[15:0] == 0);
            check("hold_carry", carry, m[16]);
            check("hold_idx", c_index, d);
        end
    endtask

    task automatic abort_mul;
        bit we_seen;
        we_seen = 1'b0;
        cur_op = 7;
        @(negedge clk);
        start = 1'b1; op = 3'd7; a_in = 16'd1234; b_in = 16'd4321; dest = 3'd5;
        for (int cyc = 1; cyc <= 9; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            we_seen |= we;
            if (cyc == 8) reset = 1'b1;
        end
        check("abort_we_seen", we_seen, 0);
        check_zero_outputs("abort");
        reset = 1'b0;
    endtask

    function automatic logic [15:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h8000;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        reset = 1'b0;
        run_op(3'd0, 16'h7FFF, 16'h0001, 3'd3, 1'b0);
        run_op(3'd0, 16'hFFFF, 16'h0001, 3'd2, 1'b0);
        run_op(3'd1, 16'd5, 16'd7, 3'd1, 1'b0);
        run_op(3'd5, 16'h0001, 16'h0013, 3'd4, 1'b0);
        run_op(3'd6, 16'h8000, 16'h000F, 3'd5, 1'b0);
        run_op(3'd7, 16'd300, 16'd200, 3'd7, 1'b1);
        run_op(3'd7, 16'h0100, 16'h0100, 3'd6, 1'b0);
        run_op(3'd2, 16'hF0F0, 16'h3C3C, 3'd0, 1'b1);
        run_op(3'd3, 16'hF0F0, 16'h0F0F, 3'd1, 1'b0);
        run_op(3'd4, 16'hAAAA, 16'hAAAA, 3'd2, 1'b0);
        abort_mul();
        run_op(3'd0, 16'd10, 16'd20, 3'd4, 1'b0);
        cur_op = 0;
        @(negedge clk);
        reset = 1'b1; start = 1'b1; op = 3'd0; a_in = 16'd1; b_in = 16'd1; dest = 3'd2;
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        check_zero_outputs("rst_start");
        @(negedge clk);
        check("rst_start_busy2", busy, 0);
        check("rst_start_we2", we, 0);
        for (int i = 0; i < 60; i++) begin
            run_op(3'($urandom_range(0, 7)), pick_operand(), pick_operand(),
                   3'($urandom), bit'($urandom_range(0, 1)));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/exec_unit.md
Name: exec_unit

Overview:
Execute stage directly downstream of the 8x16 register file.
- Consumes the two read-port values (a, b) plus an opcode and destination index.
- Computes a 16-bit result through a small FSM: single-cycle ALU ops, or a 16-iteration shift-add multiply.
- Drives the register file write port (we, c_index, d_input) for exactly one cycle per accepted operation.

Parameters:
WIDTH, 16, datapath width (must match register width)
REGBITS, 3, register index width (8 registers)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
start  in  1  request; sampled only in IDLE
op  in  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR, 111 MUL
dest  in  REGBITS  destination register index
a_in  in  WIDTH  operand A (register file a_output)
b_in  in  WIDTH  operand B (register file b_output)
busy  out  1  high whenever FSM not in IDLE
we  out  1  register file write enable, one-cycle pulse
c_index  out  REGBITS  write index to register file
result  out  WIDTH  write data to register file d_input
zero  out  1  result == 0, registered
carry  out  1  carry/borrow/overflow flag, registered

Behaviour:
- Reset: state=IDLE; busy, we, c_index, result, zero, carry all 0. All outputs are registered.
- States: IDLE, MUL, WB.
- IDLE accepting start: latch op, dest, a_in, b_in.
  - Non-MUL op: compute and register result and flags, go to WB.
  - MUL: clear accumulator and counter, go to MUL.
- IDLE with start low: stay in IDLE.
- MUL: one shift-add step per cycle, 16 cycles, LSB-first on the latched B. Counter 0..15; go to WB after step 15.
- WB: we=1, c_index=dest latched at accept. Return to IDLE next cycle. we is low in every other state.
- Latency, start accepted at edge N:
  - Non-MUL: we high in cycle N+1.
  - MUL: we high in cycle N+17.
  - busy high for 1 (non-MUL) or 17 (MUL) cycles.
- Throughput: start is ignored in MUL and WB (no queuing). Next accept is earliest in the cycle after WB.
- Arithmetic:
  - ADD: carry = bit 16 of the 17-bit sum.
  - SUB: a-b mod 2^16; carry = 1 iff a<b unsigned (borrow).
  - AND/OR/XOR: carry = 0.
  - SHL/SHR: logical shift by b[3:0]; b[15:4] ignored; carry = 0.
  - MUL: result = low 16 bits of the 32-bit unsigned product; carry = 1 iff the high 16 bits are nonzero.
- zero = (result == 0) for every op, including a truncated MUL.
- result, c_index, zero, carry: update only on entry to WB, hold all other cycles.
- Reset mid-operation: synchronous abort to IDLE. No write is issued; outputs are cleared.
- Reset and start in the same cycle: reset wins; start is dropped.
- dest == a or b register: legal. Operands were latched at accept, so the write-back does not perturb the computation.

Decomposition:
- Package exec_pkg:
  - op_t enum (3-bit, encoding above)
  - state_t enum (IDLE, MUL, WB)
  - WIDTH and REGBITS constants
  - MUL_STEPS = 16
- Sub-module mul_seq: shift-add multiplier.
  - Inputs: clk, reset, load, a, b.
  - Outputs: product[2*WIDTH-1:0], last.
  - Instantiated once; exec_unit drives load on MUL accept and moves to WB on last.

Test Plan:
1. ADD a=0x7FFF b=0x0001 dest=3, start at edge N -> cycle N+1: we=1, c_index=3, result=0x8000, zero=0, carry=0. Cycle N+2: we=0, busy=0.
2. ADD a=0xFFFF b=0x0001 -> result=0x0000, zero=1, carry=1. SUB a=5 b=7 -> result=0xFFFE, carry=1, zero=0.
3. SHL a=0x0001 b=0x0013 -> result=0x0008 (shift 3). SHR a=0x8000 b=0x000F -> result=0x0001.
4. MUL a=300 b=200 dest=7 -> busy high 17 cycles; we exactly at N+17; result=0xEA60, carry=0. Extra start pulses at N+5 and N+17 are ignored, with no second we.
5. MUL a=0x0100 b=0x0100 -> result=0x0000, zero=1, carry=1. Flags hold unchanged through the following idle cycles.
6. Start MUL, assert reset at cycle N+8 -> busy=0 and all outputs 0 at N+9; we never pulses. A new ADD accepted at N+10 completes normally.
